// File: rtl/transmission_estimator_pipe.sv
// Transmission estimate T(x) = ONE - omega*min, clamped to T0, with per-frame clamp count.
// Two-stage stallable valid/ready pipeline; omega/T0 latched on the first beat of each frame.
module transmission_estimator_pipe #(
  parameter int          WIDTH     = 16,
  parameter int          CNT_W     = 22,
  parameter int unsigned OMEGA_RST = 62259,
  parameter int unsigned T0_RST    = 21299
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cfg_omega,
  input  logic [WIDTH-1:0] cfg_t0,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_clamped,
  input  logic             out_ready,
  output logic [CNT_W-1:0] clamp_count,
  output logic             clamp_count_valid
);

  localparam logic [WIDTH-1:0] ONE        = '1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] OMEGA_INIT = WIDTH'(OMEGA_RST);
  localparam logic [WIDTH-1:0] T0_INIT    = WIDTH'(T0_RST);

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             last1_q, last1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_clamped_q, out_clamped_d;
  logic [WIDTH-1:0] omega_q, omega_d;
  logic [WIDTH-1:0] t0_q, t0_d;
  logic             sof_q, sof_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] clamp_count_q, clamp_count_d;
  logic             clamp_count_valid_q, clamp_count_valid_d;

  logic               advance, accept, out_xfer, clamp;
  logic [WIDTH-1:0]   omega_use;
  logic [2*WIDTH-1:0] product;
  logic [CNT_W-1:0]   cnt_next;

  always_comb begin
    advance   = !v2_q || out_ready;
    in_ready  = !v1_q || advance;
    accept    = in_valid && in_ready;
    out_xfer  = v2_q && out_ready;
    // The first beat of a frame already uses the freshly sampled omega.
    omega_use = sof_q ? cfg_omega : omega_q;
    product   = {{WIDTH{1'b0}}, in_data} * {{WIDTH{1'b0}}, omega_use};
    clamp     = prod_q > (ONE - t0_q);
    cnt_next  = (frame_cnt_q == CNT_MAX) ? frame_cnt_q
                                         : frame_cnt_q + CNT_W'(out_clamped_q);

    v1_d                = v1_q;
    prod_d              = prod_q;
    last1_d             = last1_q;
    v2_d                = v2_q;
    out_data_d          = out_data_q;
    out_last_d          = out_last_q;
    out_clamped_d       = out_clamped_q;
    omega_d             = omega_q;
    t0_d                = t0_q;
    sof_d               = sof_q;
    frame_cnt_d         = frame_cnt_q;
    clamp_count_d       = clamp_count_q;
    clamp_count_valid_d = 1'b0;

    if (accept) begin
      v1_d    = 1'b1;
      prod_d  = product[2*WIDTH-1:WIDTH];
      last1_d = in_last;
      sof_d   = in_last;
      if (sof_q) begin
        omega_d = cfg_omega;
        t0_d    = cfg_t0;
      end
    end else if (advance) begin
      v1_d = 1'b0;
    end

    // t0_q still holds the old frame's value on the edge a new frame latches,
    // which is exactly the beat leaving stage 1 at that edge.
    if (advance) begin
      v2_d          = v1_q;
      out_data_d    = clamp ? t0_q : ONE - prod_q;
      out_last_d    = last1_q;
      out_clamped_d = clamp;
    end

    if (out_xfer) begin
      if (out_last_q) begin
        clamp_count_d       = cnt_next;
        clamp_count_valid_d = 1'b1;
        frame_cnt_d         = '0;
      end else begin
        frame_cnt_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q                <= 1'b0;
      prod_q              <= '0;
      last1_q             <= 1'b0;
      v2_q                <= 1'b0;
      out_data_q          <= '0;
      out_last_q          <= 1'b0;
      out_clamped_q       <= 1'b0;
      omega_q             <= OMEGA_INIT;
      t0_q                <= T0_INIT;
      sof_q               <= 1'b1;
      frame_cnt_q         <= '0;
      clamp_count_q       <= '0;
      clamp_count_valid_q <= 1'b0;
    end else begin
      v1_q                <= v1_d;
      prod_q              <= prod_d;
      last1_q             <= last1_d;
      v2_q                <= v2_d;
      out_data_q          <= out_data_d;
      out_last_q          <= out_last_d;
      out_clamped_q       <= out_clamped_d;
      omega_q             <= omega_d;
      t0_q                <= t0_d;
      sof_q               <= sof_d;
      frame_cnt_q         <= frame_cnt_d;
      clamp_count_q       <= clamp_count_d;
      clamp_count_valid_q <= clamp_count_valid_d;
    end
  end

  assign out_valid         = v2_q;
  assign out_data          = out_data_q;
  assign out_last          = out_last_q;
  assign out_clamped       = out_clamped_q;
  assign clamp_count       = clamp_count_q;
  assign clamp_count_valid = clamp_count_valid_q;

endmodule

// File: tb/tb_transmission_estimator_pipe.sv
// Scoreboard bench for transmission_estimator_pipe: driver pushes expectations, monitor pops on transfers.
module tb_transmission_estimator_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] cfg_omega = 16'd62259;
  logic [15:0] cfg_t0 = 16'd21299;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_clamped;
  logic        out_ready = 1'b1;
  logic [21:0] clamp_count;
  logic        clamp_count_valid;

  transmission_estimator_pipe #(
    .WIDTH(16), .CNT_W(22), .OMEGA_RST(62259), .T0_RST(21299)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cfg_omega(cfg_omega), .cfg_t0(cfg_t0),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_clamped(out_clamped), .out_ready(out_ready),
    .clamp_count(clamp_count), .clamp_count_valid(clamp_count_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit          l;
    bit          c;
  } beat_t;

  beat_t exp_q[$];
  int    cnt_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model state: frame-level view of omega/T0 and the running clamp tally.
  bit          m_sof = 1'b1;
  logic [15:0] m_om;
  logic [15:0] m_t0;
  int          m_fcnt = 0;

  bit force_stall = 1'b0;
  bit rand_bp = 1'b0;
  int stall_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input bit last, input bit use_exp,
                              input logic [15:0] ed, input bit ec);
    longint p;
    beat_t  b;
    if (m_sof) begin
      m_om = cfg_omega;
      m_t0 = cfg_t0;
    end
    p   = (longint'(d) * longint'(m_om)) / 65536;
    b.c = p > (65535 - longint'(m_t0));
    b.d = b.c ? m_t0 : 16'(65535 - p);
    if (use_exp) begin
      b.d = ed;
      b.c = ec;
    end
    b.l = last;
    exp_q.push_back(b);
    m_fcnt += int'(b.c);
    if (last) begin
      cnt_q.push_back(m_fcnt);
      m_fcnt = 0;
    end
    m_sof = last;
  endtask

  task automatic send(input logic [15:0] d, input bit last, input bit use_exp = 1'b0,
                      input logic [15:0] ed = '0, input bit ec = 1'b0);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        model_accept(d, last, use_exp, ed, ec);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_beats_left", exp_q.size(), 0);
    chk("drain_counts_left", cnt_q.size(), 0);
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (force_stall) out_ready = 1'b0;
      else if (stall_cnt > 0) begin
        stall_cnt--;
        out_ready = 1'b0;
      end else if (rand_bp) out_ready = ($urandom_range(3) != 0);
      else out_ready = 1'b1;
    end
  end

  // Monitor: occupancy, stall stability, beat scoreboard, count pulse alignment.
  int          occ = 0;
  bit          hold = 1'b0;
  bit          last_prev = 1'b0;
  logic [15:0] hd;
  bit          hl, hc;
  always @(negedge clk) begin
    if (rst) begin
      occ       = 0;
      hold      = 1'b0;
      last_prev = 1'b0;
    end else begin
      bit acc, xfer;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      chk("in_ready", in_ready, !(occ == 2 && !out_ready));
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_last", out_last, hl);
        chk("stall_clamped", out_clamped, hc);
      end
      if (last_prev || clamp_count_valid) begin
        chk("count_pulse", clamp_count_valid, last_prev);
        if (clamp_count_valid) begin
          if (cnt_q.size() != 0) chk("clamp_count", clamp_count, cnt_q.pop_front());
          else chk("count_unexpected", 1, 0);
        end
      end
      if (xfer) begin
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_last", out_last, b.l);
          chk("out_clamped", out_clamped, b.c);
        end else chk("beat_unexpected", 1, 0);
      end
      hold      = out_valid && !out_ready;
      hd        = out_data;
      hl        = out_last;
      hc        = out_clamped;
      last_prev = xfer && out_last;
      occ       = occ + int'(acc) - int'(xfer);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] t3[10];
    t3 = '{16'd50000, 16'd1000, 16'd60000, 16'd20000, 16'd44238,
           16'd44237, 16'd65535, 16'd0, 16'd30000, 16'd12345};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_clamped", out_clamped, 0);
    chk("rst_clamp_count", clamp_count, 0);
    chk("rst_count_valid", clamp_count_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Default omega/T0, latency of two cycles
    send(16'd0, 1'b0, 1'b1, 16'd65535, 1'b0);
    @(negedge clk);
    chk("latency_cycle1", out_valid, 0);
    @(negedge clk);
    chk("latency_cycle2", out_valid, 1);
    @(posedge clk);
    #1;
    send(16'd32768, 1'b0, 1'b1, 16'd34406, 1'b0);
    send(16'd65535, 1'b1, 1'b1, 16'd21299, 1'b1);

    // Strict threshold
    cfg_omega = 16'd65535;
    cfg_t0    = 16'd21299;
    send(16'd44237, 1'b0, 1'b1, 16'd21299, 1'b0);
    send(16'd44238, 1'b1, 1'b1, 16'd21299, 1'b1);

    // Ten-beat frame with four clamps
    for (int i = 0; i < 10; i++) send(t3[i], i == 9);
    drain();

    // Mid-frame omega change takes effect on the next frame only
    send(16'd10000, 1'b0, 1'b1, 16'd55536, 1'b0);
    cfg_omega = 16'd32768;
    send(16'd10000, 1'b1, 1'b1, 16'd55536, 1'b0);
    send(16'd65535, 1'b1, 1'b1, 16'd32768, 1'b0);
    drain();

    // Random traffic with backpressure and a five-cycle stall
    rand_bp = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int n;
      cfg_omega = 16'($urandom_range(65535));
      cfg_t0    = (f == 3) ? 16'd0 : 16'($urandom_range(65535));
      n = (f == 2) ? 1 : int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) begin
        if (f == 4 && i == 1) stall_cnt = 5;
        send(16'($urandom_range(65535)), i == n - 1);
        if ($urandom_range(3) == 0) cfg_omega = 16'($urandom_range(65535));
        repeat ($urandom_range(2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_bp = 1'b0;
    drain();

    // Reset with two beats in flight
    force_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(16'd1000, 1'b0);
    send(16'd2000, 1'b0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    cnt_q.delete();
    m_sof  = 1'b1;
    m_fcnt = 0;
    force_stall = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_clamp_count", clamp_count, 0);
    cfg_omega = 16'd32768;
    cfg_t0    = 16'd100;
    @(posedge clk);
    #1;
    send(16'd65535, 1'b1, 1'b1, 16'd32768, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
